playback_sequencer: RTL and testbench

Parametrised song-playback engine for the electronic organ: walks a note-record memory, holds each note for its encoded duration, and drives the sound generator's `notes`/`shift` inputs and the eight key LEDs. Sits between the record memory (synchronous-read RAM port) and the sound top. Adds timed per-note durations, pause, stop, loop mode and end-of-song detection over the fixed-rate dump used today.

---
 rtl/organ_pkg.sv | 23 ++
 rtl/beat_timer.sv | 42 ++++
 rtl/playback_sequencer.sv | 172 +++++++++++++++++
 tb/tb_playback_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/organ_pkg.sv
// Shared types and note-record layout for the organ playback path.
package organ_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_GAP
  } state_t;

  localparam int DEF_TICKS_PER_BEAT = 12_500_000;

  // Record packing, MSB first: {dur, notes, shift}; shift sits at bit 0.
  function automatic int note_lsb(input int shift_w);
    return shift_w;
  endfunction

  function automatic int dur_lsb(input int shift_w, input int note_w);
    return shift_w + note_w;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Tick and beat counters for one note: counts TICKS_PER_BEAT-cycle beats while en, holds otherwise.
module beat_timer
  import organ_pkg::*;
#(
  parameter int TICKS_PER_BEAT = DEF_TICKS_PER_BEAT,
  parameter int DUR_WIDTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DUR_WIDTH-1:0] target,
  output logic                 beat_done
);

  localparam int TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
  localparam int BW = DUR_WIDTH + 1;

  logic [TICK_W-1:0]    tick_cnt;
  logic [DUR_WIDTH-1:0] beat_cnt;
  logic                 tick_wrap;

  assign tick_wrap = (tick_cnt == TICK_LAST);
  // Fires on the last tick of the last beat, so the caller leaves after exactly target beats.
  assign beat_done = en && tick_wrap && (({1'b0, beat_cnt} + BW'(1)) == {1'b0, target});

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tick_cnt <= '0;
      beat_cnt <= '0;
    end else if (en) begin
      if (tick_wrap) begin
        tick_cnt <= '0;
        beat_cnt <= beat_cnt + DUR_WIDTH'(1);
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/playback_sequencer.sv
// Song playback engine: walks note records, times each note, drives sound generator and key LEDs.
// Define PLAYBACK_GAP_EN to insert GAP_TICKS of silence after every note (articulated playback).
module playback_sequencer
  import organ_pkg::*;
#(
  parameter int NOTE_WIDTH     = 8,
  parameter int SHIFT_WIDTH    = 2,
  parameter int DUR_WIDTH      = 4,
  parameter int DEPTH          = 64,
  parameter int TICKS_PER_BEAT = DEF_TICKS_PER_BEAT,
  parameter int GAP_TICKS      = 1_000_000,
  localparam int ADDR_WIDTH    = $clog2(DEPTH),
  localparam int REC_WIDTH     = DUR_WIDTH + NOTE_WIDTH + SHIFT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pause,
  input  logic                   loop_en,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [REC_WIDTH-1:0]   rd_data,
  output logic [NOTE_WIDTH-1:0]  notes,
  output logic [SHIFT_WIDTH-1:0] shift,
  output logic [NOTE_WIDTH-1:0]  leds,
  output logic                   busy,
  output logic                   done
);

  localparam int NOTE_LSB = note_lsb(SHIFT_WIDTH);
  localparam int DUR_LSB  = dur_lsb(SHIFT_WIDTH, NOTE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [ADDR_WIDTH-1:0]  fetch_addr;
  logic [NOTE_WIDTH-1:0]  note_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [DUR_WIDTH-1:0]   dur_q;
  logic [DUR_WIDTH-1:0]   rd_dur;
  logic [NOTE_WIDTH-1:0]  rd_notes;
  logic [SHIFT_WIDTH-1:0] rd_shift;
  logic                   timer_clr;
  logic                   timer_en;
  logic                   beat_done;
  logic                   step_now;
  logic                   at_last;
  logic                   song_end;
  logic                   go_idle;
  logic                   go_fetch;

  assign rd_dur   = rd_data[DUR_LSB +: DUR_WIDTH];
  assign rd_notes = rd_data[NOTE_LSB +: NOTE_WIDTH];
  assign rd_shift = rd_data[0 +: SHIFT_WIDTH];
  assign leds     = notes;

  assign timer_clr = (state == S_LATCH);
  assign timer_en  = (state == S_PLAY) && !pause;

  beat_timer #(
    .TICKS_PER_BEAT(TICKS_PER_BEAT),
    .DUR_WIDTH     (DUR_WIDTH)
  ) u_beat_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .en       (timer_en),
    .target   (dur_q),
    .beat_done(beat_done)
  );

`ifdef PLAYBACK_GAP_EN
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  logic [GAP_W-1:0] gap_cnt;
  assign step_now = (state == S_GAP) && !pause && (gap_cnt == GAP_LAST);
`else
  assign step_now = beat_done;
`endif

  // Sequencing decisions shared by every path back to FETCH or IDLE.
  assign at_last    = (addr == LAST_ADDR);
  assign song_end   = ((state == S_LATCH) && (rd_dur == '0)) || (step_now && at_last);
  assign go_idle    = stop || (song_end && !loop_en);
  assign go_fetch   = ((state == S_IDLE) && start) || (song_end && loop_en) || (step_now && !at_last);
  assign fetch_addr = (step_now && !at_last) ? addr + ADDR_WIDTH'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr    <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      notes   <= '0;
      shift   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef PLAYBACK_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (go_idle) begin
        state   <= S_IDLE;
        addr    <= '0;
        rd_en   <= 1'b0;
        rd_addr <= '0;
        notes   <= '0;
        shift   <= '0;
        busy    <= 1'b0;
        done    <= !stop;
      end else if (go_fetch) begin
        state   <= S_FETCH;
        addr    <= fetch_addr;
        rd_en   <= 1'b1;
        rd_addr <= fetch_addr;
        busy    <= 1'b1;
`ifdef PLAYBACK_GAP_EN
        notes   <= '0;
        shift   <= '0;
`endif
      end else begin
        case (state)
          S_FETCH: begin
            state <= S_LATCH;
            rd_en <= 1'b0;
          end
          S_LATCH: begin
            state <= S_PLAY;
            notes <= rd_notes;
            shift <= rd_shift;
          end
          S_PLAY: begin
            if (pause) begin
              notes <= '0;
              shift <= '0;
            end
`ifdef PLAYBACK_GAP_EN
            else if (beat_done) begin
              state   <= S_GAP;
              notes   <= '0;
              shift   <= '0;
              gap_cnt <= '0;
            end
`endif
            else begin
              notes <= note_q;
              shift <= shift_q;
            end
          end
`ifdef PLAYBACK_GAP_EN
          S_GAP: begin
            if (!pause) gap_cnt <= gap_cnt + GAP_W'(1);
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Record capture: the RAM data is valid during LATCH.
  always_ff @(posedge clk) begin
    if (state == S_LATCH) begin
      note_q  <= rd_notes;
      shift_q <= rd_shift;
      dur_q   <= rd_dur;
    end
  end

endmodule

// File: tb/tb_playback_sequencer.sv
// Self-checking bench for playback_sequencer: directed song table, loop/pause/stop sequences, random songs.
module tb_playback_sequencer;

  localparam int TPB       = 4;
  localparam int GAP       = 2;
  localparam int DEPTH     = 4;
  localparam int PAUSE_LEN = 7;
`ifdef PLAYBACK_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif
  localparam int GAP_N = GAP_ON ? GAP : 0;

  logic        clk = 1'b0;
  logic        rst, start, stop, pause, loop_en;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [13:0] rd_data = '0;
  logic [7:0]  notes, leds;
  logic [1:0]  shift;
  logic        busy, done;

  logic [13:0] mem [0:DEPTH-1];
  int cyc, checks, errors;

  typedef struct packed {
    logic       pause;
    logic       lp;
    logic [7:0] notes;
    logic [1:0] shift;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic       busy;
    logic       done;
  } step_t;

  typedef struct {
    int    lo;
    int    hi;
    step_t e;
  } row_t;

  step_t exp_q[$];
  row_t  tbl[$];

  playback_sequencer #(
    .NOTE_WIDTH(8), .SHIFT_WIDTH(2), .DUR_WIDTH(4), .DEPTH(DEPTH),
    .TICKS_PER_BEAT(TPB), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .notes(notes), .shift(shift), .leds(leds), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic step_t mk_step(input int pz, input int lp, input int n, input int s,
                                    input int re, input int ad, input int b, input int d);
    step_t e;
    e.pause   = 1'(pz);
    e.lp      = 1'(lp);
    e.notes   = 8'(n);
    e.shift   = 2'(s);
    e.rd_en   = 1'(re);
    e.rd_addr = 2'(ad);
    e.busy    = 1'(b);
    e.done    = 1'(d);
    return e;
  endfunction

  task automatic row(input int lo, input int hi, input int n, input int s,
                     input int re, input int ad, input int b, input int d);
    row_t r;
    r.lo = lo;
    r.hi = hi;
    r.e  = mk_step(0, 0, n, s, re, ad, b, d);
    tbl.push_back(r);
  endtask

  task automatic push(input int pz, input int lp, input int n, input int s,
                      input int re, input int ad, input int b, input int d);
    exp_q.push_back(mk_step(pz, lp, n, s, re, ad, b, d));
  endtask

  task automatic chk_step(input string name, input step_t e);
    chk(name, 32'({notes, shift, leds, rd_en, (e.rd_en ? rd_addr : 2'b00), busy, done}),
              32'({e.notes, e.shift, e.notes, e.rd_en, e.rd_addr, e.busy, e.done}));
  endtask

  // Reference: expected per-cycle outputs from the cycle after start, built from the song's
  // timing rules (2-cycle fetch overhead, dur*TPB note, optional gap, end/loop at marker or last address).
  task automatic gen_song(input int loops, input int pnote, input int poff);
    int a, pass, played, lp, pn, ps, d, n, s;
    exp_q.delete();
    a = 0; pass = 0; played = 0; pn = 0; ps = 0;
    for (int guard = 0; guard < 64; guard++) begin
      lp = (pass < loops) ? 1 : 0;
      if (GAP_ON) begin pn = 0; ps = 0; end
      push(0, lp, pn, ps, 1, a, 1, 0);
      push(0, lp, pn, ps, 0, 0, 1, 0);
      d = int'(mem[a][13:10]);
      n = int'(mem[a][9:2]);
      s = int'(mem[a][1:0]);
      if (d != 0) begin
        for (int v = 0; v < d * TPB; v++) begin
          if (played == pnote && v == poff) begin
            push(1, lp, n, s, 0, 0, 1, 0);
            for (int z = 0; z < PAUSE_LEN; z++) push((z < PAUSE_LEN - 1) ? 1 : 0, lp, 0, 0, 0, 0, 1, 0);
          end else begin
            push(0, lp, n, s, 0, 0, 1, 0);
          end
        end
        for (int g = 0; g < GAP_N; g++) push(0, lp, 0, 0, 0, 0, 1, 0);
        pn = n; ps = s;
        played++;
      end
      if (d == 0 || a == DEPTH - 1) begin
        if (lp != 0) begin
          pass++;
          a = 0;
        end else begin
          push(0, 0, 0, 0, 0, 0, 0, 1);
          push(0, 0, 0, 0, 0, 0, 0, 0);
          break;
        end
      end else begin
        a++;
      end
    end
  endtask

  task automatic run_queue(input string name);
    start = 1'b1;
    step();
    start = 1'b0;
    foreach (exp_q[i]) begin
      pause   = exp_q[i].pause;
      loop_en = exp_q[i].lp;
      chk_step(name, exp_q[i]);
      step();
    end
    pause   = 1'b0;
    loop_en = 1'b0;
  endtask

  initial begin
    int last_c, poff, pnote, loops;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    cyc = 0; checks = 0; errors = 0;
    mem[0] = {4'd2, 8'h01, 2'd0};
    mem[1] = {4'd1, 8'h80, 2'd1};
    mem[2] = {4'd0, 8'h00, 2'd0};
    mem[3] = {4'd3, 8'h55, 2'd2};

    step(); step(); step();
    rst = 1'b0;
    chk("reset_state", 32'({notes, shift, leds, rd_en, rd_addr, busy, done}), 32'h0);

    // Directed song, start sampled in cycle 10.
    row(10, 10, 0, 0, 0, 0, 0, 0);
    row(11, 11, 0, 0, 1, 0, 1, 0);
    row(12, 12, 0, 0, 0, 0, 1, 0);
    row(13, 20, 8'h01, 0, 0, 0, 1, 0);
`ifdef PLAYBACK_GAP_EN
    row(21, 22, 0, 0, 0, 0, 1, 0);
    row(23, 23, 0, 0, 1, 1, 1, 0);
    row(24, 24, 0, 0, 0, 0, 1, 0);
    row(25, 28, 8'h80, 1, 0, 0, 1, 0);
    row(29, 30, 0, 0, 0, 0, 1, 0);
    row(31, 31, 0, 0, 1, 2, 1, 0);
    row(32, 32, 0, 0, 0, 0, 1, 0);
    row(33, 33, 0, 0, 0, 0, 0, 1);
    row(34, 35, 0, 0, 0, 0, 0, 0);
`else
    row(21, 21, 8'h01, 0, 1, 1, 1, 0);
    row(22, 22, 8'h01, 0, 0, 0, 1, 0);
    row(23, 26, 8'h80, 1, 0, 0, 1, 0);
    row(27, 27, 8'h80, 1, 1, 2, 1, 0);
    row(28, 28, 8'h80, 1, 0, 0, 1, 0);
    row(29, 29, 0, 0, 0, 0, 0, 1);
    row(30, 31, 0, 0, 0, 0, 0, 0);
`endif
    while (cyc < 10) step();
    last_c = tbl[tbl.size() - 1].hi;
    for (int c = 10; c <= last_c; c++) begin
      start = (c == 10);
      foreach (tbl[r]) if (c >= tbl[r].lo && c <= tbl[r].hi) chk_step("song_table", tbl[r].e);
      step();
    end
    start = 1'b0;

    // Loop mode: two looping passes over four notes, then a final pass ending in done.
    mem[0] = {4'd1, 8'h11, 2'd1};
    mem[1] = {4'd2, 8'h22, 2'd2};
    mem[2] = {4'd1, 8'h44, 2'd3};
    mem[3] = {4'd1, 8'h88, 2'd0};
    gen_song(2, -1, 0);
    run_queue("loop_song");

    // Pause for 7 cycles in the middle of a 3-beat note.
    mem[0] = {4'd3, 8'h3C, 2'd1};
    mem[1] = {4'd0, 8'h00, 2'd0};
    gen_song(0, 0, 5);
    run_queue("pause_note");

    // Random songs, random loop count and pause placement.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] = {4'($urandom_range(0, 3)), 8'($urandom), 2'($urandom_range(0, 3))};
      mem[0][13:10] = 4'($urandom_range(1, 3));
      poff  = $urandom_range(0, int'(mem[0][13:10]) * TPB - 2);
      pnote = ($urandom_range(0, 1) == 1) ? 0 : -1;
      loops = $urandom_range(0, 1);
      gen_song(loops, pnote, poff);
      run_queue("random_song");
    end

    // Reset in the middle of a note.
    mem[0] = {4'd2, 8'h3C, 2'd2};
    mem[1] = {4'd1, 8'h81, 2'd1};
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("playing_before_rst", 32'({notes, busy}), 32'({8'h3C, 1'b1}));
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_play", 32'({notes, shift, leds, rd_en, rd_addr, busy, done}), 32'h0);

    // stop coincident with start in IDLE.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("stop_start_idle", 32'({rd_en, busy, done}), 32'h0);
    step();
    chk("stop_start_still_idle", 32'({rd_en, busy, notes}), 32'h0);

    // stop during the gap (or mid-note without the gap).
    start = 1'b1; step(); start = 1'b0;
`ifdef PLAYBACK_GAP_EN
    for (int i = 0; i < 10; i++) step();
    chk("gap_silence", 32'({busy, notes, shift}), 32'({1'b1, 8'h00, 2'd0}));
`else
    for (int i = 0; i < 4; i++) step();
    chk("legato_play", 32'({busy, notes, shift}), 32'({1'b1, 8'h3C, 2'd2}));
`endif
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_to_idle", 32'({notes, shift, leds, rd_en, rd_addr, busy, done}), 32'h0);
    step();
    chk("stop_no_done", 32'({rd_en, busy, done}), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
